// File: rtl/audio_pkg.sv
// audio_pkg: shared sample type and sizing constants for the audio sample FIFO.
package audio_pkg;
   typedef logic [15:0] sample_t;
   localparam int DEFAULT_DEPTH = 16;
   localparam int DROP_CNT_W = 16;
endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo: never-backpressuring audio sample FIFO; discards the oldest sample when full.
// Defining AUDIO_FIFO_DROP_COUNT_EN adds a saturating drop_count output.
module audio_sample_fifo
   import audio_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int WIDTH = $bits(sample_t)
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [WIDTH-1:0]           in_data,
   input  logic                       in_valid,
   output logic                       in_ready,
   output logic [WIDTH-1:0]           out_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       overflow,
   input  logic                       ovf_clear
`ifdef AUDIO_FIFO_DROP_COUNT_EN
   ,
   output logic [DROP_CNT_W-1:0]      drop_count
`endif
);
   localparam int PW = $clog2(DEPTH);
   localparam int LW = PW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0] wr_ptr, rd_ptr, rd_next;
   logic [LW-1:0] level_next;
   logic [WIDTH-1:0] head_next;
   logic push, pop, full, drop;
   assign in_ready = reset;
   assign out_valid = level != '0;
   assign push = in_valid & in_ready;
   assign pop = out_valid & out_ready;
   assign full = level == FULL;
   assign drop = push & full & ~pop;
   assign rd_next = (pop | drop) ? rd_ptr + 1'b1 : rd_ptr;
   assign level_next = (push & ~pop & ~full) ? level + 1'b1 : (pop & ~push) ? level - 1'b1 : level;
   // Next head bypasses storage when it is the sample being written this cycle.
   assign head_next = (push && rd_next == wr_ptr) ? in_data : mem[rd_next];
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= in_data;
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         out_data <= '0;
         overflow <= 1'b0;
      end else begin
         wr_ptr   <= push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr   <= rd_next;
         level    <= level_next;
         out_data <= (level_next != '0) ? head_next : out_data;
         overflow <= drop | (overflow & ~ovf_clear);
      end
`ifdef AUDIO_FIFO_DROP_COUNT_EN
   always_ff @(posedge clk or negedge reset)
      if (!reset) drop_count <= '0;
      else drop_count <= ovf_clear ? DROP_CNT_W'(drop) :
                         (drop && drop_count != '1) ? drop_count + 1'b1 : drop_count;
`endif
endmodule

// File: tb/tb_audio_sample_fifo.sv
// tb_audio_sample_fifo: vector table, corner sequences and random traffic against a queue model.
module tb_audio_sample_fifo;
   localparam int D = 16;
   localparam int W = 16;
   localparam int LW = $clog2(D) + 1;
   logic clk = 1'b0;
   logic reset = 1'b0;
   logic [W-1:0] in_data = '0;
   logic in_valid = 1'b0, out_ready = 1'b0, ovf_clear = 1'b0;
   logic in_ready, out_valid, overflow;
   logic [W-1:0] out_data;
   logic [LW-1:0] level;
`ifdef AUDIO_FIFO_DROP_COUNT_EN
   logic [15:0] drop_count;
`endif
   int checks = 0;
   int errors = 0;
   logic [W-1:0] q [$];
   logic m_ovf;
   int m_dcnt;
   logic [W-1:0] m_head;

   audio_sample_fifo #(.DEPTH(D), .WIDTH(W)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .level(level),
      .overflow(overflow), .ovf_clear(ovf_clear)
`ifdef AUDIO_FIFO_DROP_COUNT_EN
      , .drop_count(drop_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf = 1'b0;
      m_dcnt = 0;
      m_head = '0;
   endtask

   // Queue-level view: pop the head if requested, then append; a full queue loses its oldest entry.
   task automatic model_edge();
      bit drop = 1'b0;
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (in_valid) begin
         if (q.size() == D) begin
            void'(q.pop_front());
            drop = 1'b1;
         end
         q.push_back(in_data);
      end
      m_ovf = drop | (m_ovf & !ovf_clear);
      m_dcnt = ovf_clear ? int'(drop) : (drop ? (m_dcnt == 65535 ? 65535 : m_dcnt + 1) : m_dcnt);
      if (q.size() > 0) m_head = q[0];
   endtask

   task automatic compare_model();
      chk("in_ready", in_ready, 1);
      chk("out_valid", out_valid, q.size() != 0);
      chk("level", level, q.size());
      chk("out_data", out_data, m_head);
      chk("overflow", overflow, m_ovf);
`ifdef AUDIO_FIFO_DROP_COUNT_EN
      chk("drop_count", drop_count, m_dcnt);
`endif
   endtask

   task automatic drive(input bit v, input logic [W-1:0] d, input bit r, input bit c);
      in_valid = v;
      in_data = d;
      out_ready = r;
      ovf_clear = c;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare_model();
   endtask

   typedef struct {
      bit v; logic [15:0] d; bit r; bit c;
      bit ev; logic [15:0] ed; int el; bit eo;
   } vec_t;
   vec_t tv [6];

   initial begin
      tv[0] = '{1, 16'h1234, 0, 0, 1, 16'h1234, 1, 0};
      tv[1] = '{1, 16'h5678, 0, 0, 1, 16'h1234, 2, 0};
      tv[2] = '{1, 16'h9ABC, 1, 0, 1, 16'h5678, 2, 0};
      tv[3] = '{0, 16'h0000, 1, 0, 1, 16'h9ABC, 1, 0};
      tv[4] = '{0, 16'h0000, 1, 0, 0, 16'h9ABC, 0, 0};
      tv[5] = '{0, 16'h0000, 0, 1, 0, 16'h9ABC, 0, 0};
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_level", level, 0);
      chk("rst_overflow", overflow, 0);
`ifdef AUDIO_FIFO_DROP_COUNT_EN
      chk("rst_drop_count", drop_count, 0);
`endif
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 6; i++) begin
         drive(tv[i].v, tv[i].d, tv[i].r, tv[i].c);
         step();
         chk($sformatf("tv%0d_valid", i), out_valid, tv[i].ev);
         chk($sformatf("tv%0d_data", i), out_data, tv[i].ed);
         chk($sformatf("tv%0d_level", i), level, tv[i].el);
         chk($sformatf("tv%0d_ovf", i), overflow, tv[i].eo);
      end
      for (int i = 1; i <= 16; i++) begin
         drive(1, W'(i), 0, 0);
         step();
      end
      chk("fill_level", level, 16);
      chk("fill_ovf", overflow, 0);
      chk("fill_head", out_data, 1);
      drive(1, 16'd17, 0, 0);
      step();
      chk("drop_level", level, 16);
      chk("drop_ovf", overflow, 1);
      chk("drop_head", out_data, 2);
      drive(1, 16'd100, 1, 0);
      step();
      chk("pp_full_level", level, 16);
      chk("pp_full_head", out_data, 3);
      chk("pp_full_ovf", overflow, 1);
      drive(1, 16'd200, 0, 1);
      step();
      chk("clr_drop_ovf", overflow, 1);
`ifdef AUDIO_FIFO_DROP_COUNT_EN
      chk("clr_drop_cnt", drop_count, 1);
`endif
      drive(0, 0, 0, 1);
      step();
      chk("clr_ovf", overflow, 0);
`ifdef AUDIO_FIFO_DROP_COUNT_EN
      chk("clr_cnt", drop_count, 0);
`endif
      drive(0, 0, 1, 0);
      repeat (16) step();
      chk("drain_level", level, 0);
      for (int i = 0; i < 8; i++) begin
         drive(1, W'(16'hA000 + i), 0, 0);
         step();
      end
      chk("mid_level", level, 8);
      drive(0, 0, 0, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("mrst_valid", out_valid, 0);
      chk("mrst_level", level, 0);
      chk("mrst_ovf", overflow, 0);
      chk("mrst_data", out_data, 0);
      chk("mrst_in_ready", in_ready, 0);
      model_reset();
      @(posedge clk);
      @(negedge clk);
      reset = 1'b1;
      drive(1, 16'hBEEF, 0, 0);
      step();
      chk("post_rst_head", out_data, 16'hBEEF);
      chk("post_rst_level", level, 1);
      drive(0, 0, 1, 0);
      step();
      drive(1, 16'd0, 0, 0);
      step();
      for (int i = 1; i < 1000; i++) begin
         drive(1, W'(i), 1, 0);
         step();
         chk("ramp_level", level, 1);
         chk("ramp_data", out_data, i);
      end
      chk("ramp_ovf", overflow, 0);
      drive(0, 0, 1, 0);
      step();
      for (int i = 0; i < 3000; i++) begin
         drive($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0);
         step();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
